// File: rtl/ip_tile_pkg.sv
// Shared types, CSR bit positions and opcode helpers for the sequential ALU tile.
package ip_tile_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_MUL     = 3'd2,
        OP_MAC     = 3'd3,
        OP_CLR_ACC = 3'd4
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    localparam int CSR_START   = 0;
    localparam int CSR_OP_LSB  = 1;
    localparam int CSR_OP_MSB  = 3;

    localparam int CSR_DONE    = 0;
    localparam int CSR_BUSY    = 1;
    localparam int CSR_ERR     = 2;
    localparam int CSR_OVF     = 3;
    localparam int CSR_OPE_LSB = 4;
    localparam int CSR_OPE_MSB = 6;
    localparam int CSR_CNT_LSB = 8;
    localparam int CSR_CNT_MSB = 15;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MAC);
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_CLR_ACC;
    endfunction

endpackage

// File: rtl/ip_tile_seq_mul.sv
// Iterative shift-add multiplier: consumes MUL_STEP multiplier bits per cycle.
// done pulses in the Nth cycle after start; prod is valid while done is high.
module ip_tile_seq_mul #(
    parameter int REG_WIDTH = 32,
    parameter int MUL_STEP  = 1
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     start,
    input  logic [REG_WIDTH-1:0]     a,
    input  logic [REG_WIDTH-1:0]     b,
    output logic                     busy,
    output logic                     done,
    output logic [2*REG_WIDTH-1:0]   prod
);

    localparam int N  = REG_WIDTH / MUL_STEP;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic                   busy_q, busy_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*REG_WIDTH-1:0] mcand_q, mcand_d;
    logic [REG_WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*REG_WIDTH-1:0] acc_q, acc_d;
    logic [2*REG_WIDTH-1:0] step_sum;

    always_comb begin
        // Partial sum including this cycle's slice, so the last step's result is visible with done.
        step_sum = acc_q;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) step_sum = step_sum + (mcand_q << i);
        end

        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;

        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{REG_WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << MUL_STEP;
            mplier_d = mplier_q >> MUL_STEP;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == LAST);
    assign prod = step_sum;

endmodule

// File: rtl/ip_tile_seq_alu.sv
// Sequential ALU tile: accepts one command per START rising level, executes it in
// EXEC (1 cycle or N multiplier cycles) and publishes status on csr_out.
module ip_tile_seq_alu
    import ip_tile_pkg::*;
#(
    parameter int CSR_IN_WIDTH  = 16,
    parameter int CSR_OUT_WIDTH = 16,
    parameter int REG_WIDTH     = 32,
    parameter int MUL_STEP      = 1
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [CSR_IN_WIDTH-1:0]  csr_in,
    output logic                     csr_in_re,
    input  logic [REG_WIDTH-1:0]     data_reg_a,
    input  logic [REG_WIDTH-1:0]     data_reg_b,
    output logic [CSR_OUT_WIDTH-1:0] csr_out,
    output logic                     csr_out_we,
    output logic [REG_WIDTH-1:0]     data_reg_c
);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Assertion reaches every flop asynchronously; release is aligned to clk.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_e                   state_q, state_d;
    logic                     armed_q, armed_d;
    logic [REG_WIDTH-1:0]     a_q, a_d;
    logic [REG_WIDTH-1:0]     b_q, b_d;
    logic [2:0]               op_q, op_d;
    logic [REG_WIDTH-1:0]     acc_q, acc_d;
    logic [REG_WIDTH-1:0]     c_q, c_d;
    logic [CSR_OUT_WIDTH-1:0] csr_out_q, csr_out_d;
    logic                     csr_out_we_q, csr_out_we_d;
    logic                     csr_in_re_q, csr_in_re_d;

    logic                     start_bit;
    logic [2:0]               op_in;
    logic                     accept;
    logic                     exec_done;
    logic [7:0]               cnt_next;
    logic                     mul_start;
    logic                     mul_busy;
    logic                     mul_done;
    logic [2*REG_WIDTH-1:0]   mul_prod;
    logic [REG_WIDTH:0]       sum_ext;
    logic [REG_WIDTH:0]       mac_ext;
    logic                     prod_hi_nz;
    logic                     unused_csr_in;

    assign start_bit     = csr_in[CSR_START];
    assign op_in         = csr_in[CSR_OP_MSB:CSR_OP_LSB];
    assign unused_csr_in = ^{csr_in[CSR_IN_WIDTH-1:CSR_OP_MSB+1], mul_busy};
    assign accept        = (state_q == ST_IDLE) && start_bit && armed_q;
    assign exec_done     = (state_q == ST_EXEC) && (!is_mul_op(op_q) || mul_done);
    assign cnt_next      = csr_out_q[CSR_CNT_MSB:CSR_CNT_LSB] + 8'd1;
    assign mul_start     = accept && is_mul_op(op_in);

    ip_tile_seq_mul #(
        .REG_WIDTH (REG_WIDTH),
        .MUL_STEP  (MUL_STEP)
    ) u_mul (
        .clk    (clk),
        .arst_n (rst_n),
        .start  (mul_start),
        .a      (data_reg_a),
        .b      (data_reg_b),
        .busy   (mul_busy),
        .done   (mul_done),
        .prod   (mul_prod)
    );

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        acc_d        = acc_q;
        c_d          = c_q;
        csr_out_d    = csr_out_q;
        csr_out_we_d = 1'b0;
        csr_in_re_d  = 1'b0;

        sum_ext    = {1'b0, a_q} + {1'b0, b_q};
        mac_ext    = {1'b0, acc_q} + {1'b0, mul_prod[REG_WIDTH-1:0]};
        prod_hi_nz = |mul_prod[2*REG_WIDTH-1:REG_WIDTH];

        // Re-arming only happens in IDLE, so a START toggled while busy never queues a command.
        if ((state_q == ST_IDLE) && !start_bit) armed_d = 1'b1;

        if (accept) begin
            armed_d      = 1'b0;
            state_d      = ST_EXEC;
            a_d          = data_reg_a;
            b_d          = data_reg_b;
            op_d         = op_in;
            csr_in_re_d  = 1'b1;
            csr_out_we_d = 1'b1;
            csr_out_d    = '0;
            csr_out_d[CSR_CNT_MSB:CSR_CNT_LSB] = cnt_next;
            csr_out_d[CSR_OPE_MSB:CSR_OPE_LSB] = op_in;
            csr_out_d[CSR_BUSY]                = 1'b1;
        end

        if (exec_done) begin
            state_d                 = ST_IDLE;
            csr_out_we_d            = 1'b1;
            csr_out_d[CSR_BUSY]     = 1'b0;
            csr_out_d[CSR_DONE]     = 1'b1;
            csr_out_d[CSR_ERR]      = 1'b0;
            csr_out_d[CSR_OVF]      = 1'b0;
            case (op_q)
                OP_ADD: begin
                    c_d                = sum_ext[REG_WIDTH-1:0];
                    csr_out_d[CSR_OVF] = sum_ext[REG_WIDTH];
                end
                OP_SUB: begin
                    c_d                = a_q - b_q;
                    csr_out_d[CSR_OVF] = a_q < b_q;
                end
                OP_MUL: begin
                    c_d                = mul_prod[REG_WIDTH-1:0];
                    csr_out_d[CSR_OVF] = prod_hi_nz;
                end
                OP_MAC: begin
                    acc_d              = mac_ext[REG_WIDTH-1:0];
                    c_d                = mac_ext[REG_WIDTH-1:0];
                    csr_out_d[CSR_OVF] = mac_ext[REG_WIDTH] | prod_hi_nz;
                end
                OP_CLR_ACC: begin
                    acc_d = '0;
                    c_d   = '0;
                end
                default: begin
                    csr_out_d[CSR_ERR] = !is_legal_op(op_q);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            acc_q        <= '0;
            c_q          <= '0;
            csr_out_q    <= '0;
            csr_out_we_q <= 1'b0;
            csr_in_re_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            acc_q        <= acc_d;
            c_q          <= c_d;
            csr_out_q    <= csr_out_d;
            csr_out_we_q <= csr_out_we_d;
            csr_in_re_q  <= csr_in_re_d;
        end
    end

    assign csr_in_re  = csr_in_re_q;
    assign csr_out    = csr_out_q;
    assign csr_out_we = csr_out_we_q;
    assign data_reg_c = c_q;

endmodule

// File: tb/tb_ip_tile_seq_alu.sv
// Directed bench for ip_tile_seq_alu: hand-computed csr_out / data_reg_c values per step.
module tb_ip_tile_seq_alu;

    logic        clk;
    logic        arst_n;
    logic [15:0] csr_in;
    logic        csr_in_re;
    logic [31:0] data_reg_a;
    logic [31:0] data_reg_b;
    logic [15:0] csr_out;
    logic        csr_out_we;
    logic [31:0] data_reg_c;

    int n_assert;
    int n_fail;
    int we_cnt;
    int re_cnt;
    int we_base;
    int re_base;

    ip_tile_seq_alu #(
        .CSR_IN_WIDTH  (16),
        .CSR_OUT_WIDTH (16),
        .REG_WIDTH     (32),
        .MUL_STEP      (1)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .csr_in     (csr_in),
        .csr_in_re  (csr_in_re),
        .data_reg_a (data_reg_a),
        .data_reg_b (data_reg_b),
        .csr_out    (csr_out),
        .csr_out_we (csr_out_we),
        .data_reg_c (data_reg_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (csr_out_we) we_cnt <= we_cnt + 1;
        if (csr_in_re)  re_cnt <= re_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, drop START after the accept, wait for DONE, then give one IDLE cycle to re-arm.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int max_cyc);
        data_reg_a = a;
        data_reg_b = b;
        csr_in     = {12'd0, op, 1'b1};
        tick();
        check({tag, "_re"}, 64'(csr_in_re), 64'd1);
        csr_in = 16'h0000;
        for (int i = 0; i < max_cyc; i++) begin
            if (csr_out[0]) break;
            tick();
        end
        check({tag, "_done_seen"}, 64'(csr_out[0]), 64'd1);
        tick();
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        we_cnt     = 0;
        re_cnt     = 0;
        arst_n     = 1'b0;
        csr_in     = 16'h0000;
        data_reg_a = '0;
        data_reg_b = '0;
        repeat (3) tick();
        check("rst_csr_out", 64'(csr_out), 64'h0);
        check("rst_we", 64'(csr_out_we), 64'd0);
        check("rst_re", 64'(csr_in_re), 64'd0);
        check("rst_c", 64'(data_reg_c), 64'h0);
        arst_n = 1'b1;
        repeat (4) tick();
        check("idle_csr_out", 64'(csr_out), 64'h0);

        // ADD with carry out
        data_reg_a = 32'hFFFF_FFFF;
        data_reg_b = 32'd2;
        csr_in     = 16'h0001;
        tick();
        check("add_re", 64'(csr_in_re), 64'd1);
        check("add_accept_csr", 64'(csr_out), 64'h0102);
        check("add_accept_we", 64'(csr_out_we), 64'd1);
        csr_in = 16'h0000;
        tick();
        check("add_done_csr", 64'(csr_out), 64'h0109);
        check("add_c", 64'(data_reg_c), 64'h1);
        check("add_done_we", 64'(csr_out_we), 64'd1);
        check("add_re_low", 64'(csr_in_re), 64'd0);
        tick();
        check("add_we_low", 64'(csr_out_we), 64'd0);

        // MUL with high half set: busy exactly 32 cycles, two status writes
        we_base    = we_cnt;
        data_reg_a = 32'h0001_0000;
        data_reg_b = 32'h0001_0000;
        csr_in     = 16'h0005;
        tick();
        check("mul_accept_csr", 64'(csr_out), 64'h0222);
        csr_in = 16'h0000;
        repeat (31) tick();
        check("mul_busy_at_31", 64'(csr_out), 64'h0222);
        tick();
        check("mul_done_csr", 64'(csr_out), 64'h0229);
        check("mul_c", 64'(data_reg_c), 64'h0);
        tick();
        check("mul_we_pulses", 64'(we_cnt - we_base), 64'd2);
        tick();

        // CLR_ACC then two MACs
        do_cmd("clr", 3'd4, 32'd9, 32'd9, 10);
        check("clr_c", 64'(data_reg_c), 64'h0);
        check("clr_csr", 64'(csr_out), 64'h0341);
        do_cmd("mac1", 3'd3, 32'd3, 32'd5, 40);
        check("mac1_c", 64'(data_reg_c), 64'd15);
        check("mac1_csr", 64'(csr_out), 64'h0431);
        do_cmd("mac2", 3'd3, 32'd7, 32'd2, 40);
        check("mac2_c", 64'(data_reg_c), 64'd29);
        check("mac2_csr", 64'(csr_out), 64'h0531);

        // START held high across a 1-cycle op gives a single accept
        re_base    = re_cnt;
        data_reg_a = 32'd1;
        data_reg_b = 32'd1;
        csr_in     = 16'h0001;
        repeat (100) tick();
        check("held_c", 64'(data_reg_c), 64'd2);
        check("held_csr", 64'(csr_out), 64'h0601);
        csr_in = 16'h0000;
        repeat (2) tick();
        check("held_re_count", 64'(re_cnt - re_base), 64'd1);
        do_cmd("rearm", 3'd0, 32'd5, 32'd6, 10);
        check("rearm_c", 64'(data_reg_c), 64'd11);
        check("rearm_csr", 64'(csr_out), 64'h0701);

        // START re-raised during MUL EXEC is ignored, also after completion
        data_reg_a = 32'd3;
        data_reg_b = 32'd4;
        csr_in     = 16'h0005;
        tick();
        check("mul2_accept_csr", 64'(csr_out), 64'h0822);
        csr_in = 16'h0000;
        repeat (3) tick();
        re_base    = re_cnt;
        csr_in     = 16'h0005;
        data_reg_a = 32'hDEAD_BEEF;
        repeat (40) tick();
        check("mul2_no_reaccept", 64'(re_cnt - re_base), 64'd0);
        check("mul2_c", 64'(data_reg_c), 64'd12);
        check("mul2_csr", 64'(csr_out), 64'h0821);
        csr_in = 16'h0000;
        tick();

        // Illegal op keeps c and acc; CMD_CNT still advances
        do_cmd("illegal", 3'd6, 32'd9, 32'd9, 10);
        check("illegal_c", 64'(data_reg_c), 64'd12);
        check("illegal_csr", 64'(csr_out), 64'h0965);
        do_cmd("mac3", 3'd3, 32'd1, 32'd1, 40);
        check("mac3_c", 64'(data_reg_c), 64'd30);
        check("mac3_csr", 64'(csr_out), 64'h0A31);
        do_cmd("sub", 3'd1, 32'd5, 32'd7, 10);
        check("sub_c", 64'(data_reg_c), 64'hFFFF_FFFE);
        check("sub_csr", 64'(csr_out), 64'h0B19);

        // Reset in the middle of a MUL
        data_reg_a = 32'h0001_0000;
        data_reg_b = 32'h0001_0000;
        csr_in     = 16'h0005;
        tick();
        csr_in = 16'h0000;
        repeat (9) tick();
        we_base = we_cnt;
        arst_n  = 1'b0;
        #1;
        check("abort_csr", 64'(csr_out), 64'h0);
        check("abort_we", 64'(csr_out_we), 64'd0);
        check("abort_re", 64'(csr_in_re), 64'd0);
        check("abort_c", 64'(data_reg_c), 64'h0);
        repeat (2) tick();
        arst_n = 1'b1;
        repeat (40) tick();
        check("abort_no_done", 64'(we_cnt - we_base), 64'd0);
        do_cmd("post_rst_add", 3'd0, 32'd1, 32'd2, 10);
        check("post_rst_c", 64'(data_reg_c), 64'd3);
        check("post_rst_csr", 64'(csr_out), 64'h0101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
